// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int grant_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at rr_ptr
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   int                idx;
   logic [IDX_W-1:0]  idx_w;

   // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins last.
   always_comb begin
      winner  = '0;
      any_req = |req;
      idx     = 0;
      idx_w   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         idx_w = idx[IDX_W-1:0];
         if (req[idx_w]) begin
            winner = idx_w;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-locked round-robin arbiter driving one FIFO write port
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 8,
   localparam int GRANT_W    = grant_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          busy,
   output logic [GRANT_W-1:0]            grant_id
);

   arb_state_t          state_q, state_d;
   logic [GRANT_W-1:0]  grant_q, grant_d;
   logic [GRANT_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [GRANT_W-1:0]  pick_winner;
   logic                pick_any;
   logic                xfer;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (GRANT_W)
   ) u_rr_picker (
      .req     (req_valid),
      .rr_ptr  (rr_ptr_q),
      .winner  (pick_winner),
      .any_req (pick_any)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Ready depends only on registered grant and fifo_full, never on req_valid.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      req_ready    = '0;
      xfer         = 1'b0;
      fifo_data_in = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == GRANT_W'(i)) begin
            fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_winner;
               state_d = GRANT;
            end
         end
         GRANT: begin
            req_ready[grant_q] = !fifo_full;
            xfer = req_valid[grant_q] && !fifo_full;
            if (xfer && req_last[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign fifo_wr_en = xfer;
   assign busy       = (state_q == GRANT);
   assign grant_id   = grant_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, packet-aware arbiter sharing one `fifo` write port among NUM_REQ producers. Each producer offers data through a valid/ready handshake. The arbiter locks onto one producer for a whole packet, terminated by `req_last`. It forwards beats to the FIFO write port and never writes while the FIFO reports full. It sits directly in front of the shared `fifo` instance and is the only driver of its `wr_en` and `data_in`.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, beat width; must match the FIFO DATA_WIDTH
- GRANT_W, derived localparam = max(1, clog2(NUM_REQ)), width of grant index
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- req_valid  input  NUM_REQ  per-requester beat valid
- req_last  input  NUM_REQ  per-requester last beat of packet; qualified by valid
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester beat accepted when valid&ready
- fifo_full  input  1  full flag from FIFO
- fifo_wr_en  output  1  FIFO write enable
- fifo_data_in  output  DATA_WIDTH  FIFO write data
- busy  output  1  a packet grant is held
- grant_id  output  GRANT_W  index of the currently granted requester

## Operation
- States: IDLE, GRANT.
- IDLE: req_ready all 0; fifo_wr_en 0. If any req_valid is set, the round-robin pick registers grant_id. The search starts at rr_ptr and wraps upward. The FSM moves to GRANT on the next edge. If no valid is set, it stays in IDLE.
- GRANT: req_ready[grant_id] = !fifo_full (combinational); all other ready bits are 0.
- Beat transfer = req_valid[g] & req_ready[g].
- fifo_wr_en = transfer. fifo_data_in = req_data slice g, driven combinationally.
- Transfer with req_last[g]=1: next state IDLE; rr_ptr <= (g+1) mod NUM_REQ (wraps, including non-power-of-2 NUM_REQ).
- req_valid[g] deasserts mid-packet: the grant is held and the FSM waits indefinitely. There is no timeout.
- fifo_full high: no transfer and no write. The beat stays pending at the producer.
- Valid/last on non-granted requesters is ignored until the next IDLE arbitration.
- Single-beat packet (valid & last on the first beat): one transfer, then IDLE.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, busy 0, req_ready 0, fifo_wr_en 0. fifo_data_in is don't-care while fifo_wr_en=0.
- Reset mid-packet: the grant is dropped immediately at the reset edge. The partial packet already in the FIFO is not retracted. The upstream side owns the cleanup.

## Timing
- Arbitration latency: 1 cycle. Valid at cycle n in IDLE gives grant at n+1, with the first write possible at n+1.
- Throughput inside a packet: 1 beat/cycle while valid and !fifo_full.
- Inter-packet bubble: exactly 1 cycle (the IDLE cycle).
- busy = (state == GRANT), registered.
- fifo_full is used as sampled in the same cycle. The FIFO's registered full flag makes the full→ready path single-cycle safe.
- Write on the last free slot: full rises the next cycle, and ready drops the same cycle full is seen.
- No combinational path from req_valid to req_ready.

## Structure
- Package `fifo_arb_pkg`: state enum `arb_state_t` {IDLE, GRANT}, and function `grant_width(n)` returning max(1, clog2(n)).
- Sub-module `rr_picker`: combinational, with inputs req vector and rr_ptr, and outputs winner index and any_req. It is reused by future read-side schedulers.
- Top: FSM, rr_ptr and grant registers, data mux, ready decode.

## Test plan
- Single requester: req0 sends a 3-beat packet 0x11,0x22,0x33 (last on 0x33) → grant_id=0 one cycle after valid; three consecutive fifo_wr_en pulses with those data; busy low the cycle after 0x33.
- Fairness: all 4 requesters hold 1-beat packets continuously → grant order 0,1,2,3,0,… with one write every 2 cycles.
- Packet lock: req1 in the middle of a 4-beat packet while req0/req2 assert valid → no beat from 0/2 until req1's last; the next grant goes to 2 (rr_ptr=2), not 0.
- Backpressure: drive fifo_full=1 for 5 cycles mid-packet → req_ready and fifo_wr_en stay 0 for those cycles; the held beat 0xA5 is written in the cycle fifo_full drops.
- Valid gap: the granted producer drops valid for 3 cycles mid-packet → grant held, no writes, other requests ignored; resumes with no data loss.
- Reset mid-packet: rstn low for 1 cycle during beat 2 of req3 → next cycle busy=0, req_ready=0, grant_id=0, and arbitration restarts from requester 0.
